// File: rtl/mux_nx1_stream_arb.sv
// mux_nx1_stream_arb
// Registered N-input stream multiplexer with valid/ready handshakes.
// Mode 0 forwards the channel named by in_sel. Mode 1 arbitrates round-robin
// among the valid channels. A single output register decouples the sources
// from the sink; a new beat may load in the same cycle the held one leaves.

module mux_nx1_stream_arb #(
  parameter  int N_CH  = 2,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_mode,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic [N_CH*W-1:0]   in_src_data,
  input  logic [N_CH-1:0]     in_src_valid,
  output logic [N_CH-1:0]     out_src_ready,
  output logic [W-1:0]        out_dst_data,
  output logic                out_dst_valid,
  output logic [SEL_W-1:0]    out_dst_ch,
  input  logic                in_dst_ready
);

  // Number of codes in_sel can express; may exceed N_CH when N_CH is not
  // a power of two, and the extra codes must never produce a grant.
  localparam int SEL_N = 1 << SEL_W;

  // The pointer starts on the last channel so the first search begins at 0.
  localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(N_CH - 1);

  logic              load;
  logic [SEL_N-1:0]  valid_pad;
  logic              sel_in_range;
  logic              static_found;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_grant;
  logic [SEL_W-1:0]  rr_ptr;
  logic              grant_found;
  logic [SEL_W-1:0]  grant;
  logic              grant_valid;
  logic [W-1:0]      grant_data;

  // Channel index (base + offset) wrapped into 0..N_CH-1. Offset never
  // exceeds N_CH and base is always below N_CH, so one subtraction suffices.
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_CH) begin
      sum = sum - N_CH;
    end
    return SEL_W'(sum);
  endfunction

  // The output register may take a new beat when empty or being drained.
  always_comb begin
    load = ~out_dst_valid | in_dst_ready;
  end

  // Static select: only a valid, in-range channel can be granted.
  always_comb begin
    valid_pad    = SEL_N'(in_src_valid);
    sel_in_range = (int'(in_sel) < N_CH);
    static_found = sel_in_range && valid_pad[in_sel];
  end

  // Round-robin search starting just after the last granted channel; the
  // loop runs from the farthest candidate down so the nearest one wins.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int i = N_CH; i >= 1; i--) begin
      if (valid_pad[wrap_idx(rr_ptr, i)]) begin
        rr_found = 1'b1;
        rr_grant = wrap_idx(rr_ptr, i);
      end
    end
  end

  // Pick the grant for the active mode and qualify it with load and reset,
  // so nothing is offered to the sources while a beat is stuck or in reset.
  always_comb begin
    if (in_mode) begin
      grant_found = rr_found;
      grant       = rr_grant;
    end else begin
      grant_found = static_found;
      grant       = in_sel;
    end
    grant_valid = ~in_rst & load & grant_found;
  end

  // One-hot ready to the granted source and the matching data slice.
  always_comb begin
    out_src_ready = '0;
    grant_data    = '0;
    for (int k = 0; k < N_CH; k++) begin
      out_src_ready[k] = grant_valid && (grant == SEL_W'(k));
      if (grant == SEL_W'(k)) begin
        grant_data = in_src_data[k*W +: W];
      end
    end
  end

  // Output stage: capture the granted beat, empty when nothing is granted,
  // and hold everything while the sink is stalling.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_dst_valid <= 1'b0;
      out_dst_data  <= '0;
      out_dst_ch    <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_dst_valid <= 1'b1;
        out_dst_data  <= grant_data;
        out_dst_ch    <= grant;
      end else begin
        out_dst_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: follows transfers made in mode 1 only, so a
  // detour through static select leaves the rotation where it was.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rr_ptr <= PTR_RESET;
    end else if (grant_valid && in_mode) begin
      rr_ptr <= grant;
    end
  end

  // At most one source may ever see ready.
  assert property (@(posedge in_clk) disable iff (in_rst)
    $onehot0(out_src_ready));

  // A beat the sink has not taken stays put.
  assert property (@(posedge in_clk) disable iff (in_rst)
    (out_dst_valid && !in_dst_ready) |=>
      (out_dst_valid && $stable(out_dst_data) && $stable(out_dst_ch)));

endmodule
